// File: rtl/mips_fetch_ifid.sv
`default_nettype none
//============================================================================
// Module      : mips_fetch_ifid
// Description : Instruction-fetch stage with IF/ID pipeline register.
//               Owns the PC, runs a req/ack handshake to instruction memory,
//               honours decode stalls (via a one-word skid buffer) and
//               taken-branch redirects (draining any outstanding request).
// Revision    : 1.0 - initial release
//============================================================================
module mips_fetch_ifid #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  output logic        IfIdValid,
  output logic [31:0] IfIdInstr,
  output logic [31:0] IfIdPCPlus4,
  output logic [5:0]  Opcode,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [4:0]  Shamt,
  output logic [5:0]  Funct,
  output logic [15:0] Imm16,
  output logic [25:0] JumpAddr
);

  // IDLE   : one cycle after reset before the first request
  // FETCH  : request outstanding at r_pc
  // HOLD   : fetched word parked in skid buffer while decode stalls
  // DRAIN  : redirect seen mid-request; wait for the ack, then jump
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_skid;
  logic [31:0] r_pend;
  logic [31:0] r_instr;
  logic [31:0] r_pcp4;
  logic        r_valid;
  logic [31:0] w_pc_plus4;

  // Wraps modulo 2^32 naturally; no alignment check.
  assign w_pc_plus4 = r_pc + 32'd4;

  // Fetch FSM, PC, skid buffer and IF/ID register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_skid  <= 32'h0;
      r_pend  <= 32'h0;
      r_instr <= 32'h0;
      r_pcp4  <= 32'h0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_FETCH;
        end

        S_FETCH: begin
          if (ImemAck) begin
            if (BranchTaken) begin
              // Returned word is on the wrong path; refetch from target.
              r_pc    <= BranchTarget;
              r_valid <= 1'b0;
            end else if (Stall) begin
              // Decode busy: park the word, PC already moves on.
              r_skid  <= ImemData;
              r_pc    <= w_pc_plus4;
              r_state <= S_HOLD;
            end else begin
              r_instr <= ImemData;
              r_pcp4  <= w_pc_plus4;
              r_valid <= 1'b1;
              r_pc    <= w_pc_plus4;
            end
          end else begin
            if (BranchTaken) begin
              // Request cannot be cancelled: remember target, wait for ack.
              r_pend  <= BranchTarget;
              r_valid <= 1'b0;
              r_state <= S_DRAIN;
            end else if (!Stall) begin
              r_valid <= 1'b0;
            end
          end
        end

        S_HOLD: begin
          if (BranchTaken) begin
            r_pc    <= BranchTarget;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end else if (!Stall) begin
            // r_pc was advanced when the word was parked, so it is PC+4.
            r_instr <= r_skid;
            r_pcp4  <= r_pc;
            r_valid <= 1'b1;
            r_state <= S_FETCH;
          end
        end

        S_DRAIN: begin
          if (ImemAck) begin
            r_pc    <= BranchTaken ? BranchTarget : r_pend;
            r_state <= S_FETCH;
          end else if (BranchTaken) begin
            r_pend <= BranchTarget;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign ImemReq     = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign ImemAddr    = r_pc;
  assign IfIdValid   = r_valid;
  assign IfIdInstr   = r_instr;
  assign IfIdPCPlus4 = r_pcp4;

  assign Opcode   = r_instr[31:26];
  assign Rs       = r_instr[25:21];
  assign Rt       = r_instr[20:16];
  assign Rd       = r_instr[15:11];
  assign Shamt    = r_instr[10:6];
  assign Funct    = r_instr[5:0];
  assign Imm16    = r_instr[15:0];
  assign JumpAddr = r_instr[25:0];

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_ifid.sv
`default_nettype none
//============================================================================
// Module      : tb_mips_fetch_ifid
// Description : Directed, table-driven bench for mips_fetch_ifid, plus a
//               hand sequence on a second instance with a wrapping RESET_PC.
// Revision    : 1.0 - initial release
//============================================================================
module tb_mips_fetch_ifid;

  logic        clk = 1'b0;
  logic        rst, rst2;
  logic        ImemAck, Stall, BranchTaken;
  logic [31:0] ImemData, BranchTarget;

  logic        req_a, valid_a;
  logic [31:0] addr_a, instr_a, pcp4_a;
  logic [5:0]  op_a, fn_a;
  logic [4:0]  rs_a, rt_a, rd_a, sh_a;
  logic [15:0] imm_a;
  logic [25:0] ja_a;

  logic        req_b, valid_b;
  logic [31:0] addr_b, instr_b, pcp4_b;
  logic [5:0]  op_b, fn_b;
  logic [4:0]  rs_b, rt_b, rd_b, sh_b;
  logic [15:0] imm_b;
  logic [25:0] ja_b;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mips_fetch_ifid dut (
    .clk(clk), .rst(rst),
    .ImemReq(req_a), .ImemAddr(addr_a), .ImemAck(ImemAck), .ImemData(ImemData),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .IfIdValid(valid_a), .IfIdInstr(instr_a), .IfIdPCPlus4(pcp4_a),
    .Opcode(op_a), .Rs(rs_a), .Rt(rt_a), .Rd(rd_a), .Shamt(sh_a), .Funct(fn_a),
    .Imm16(imm_a), .JumpAddr(ja_a)
  );

  mips_fetch_ifid #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst2),
    .ImemReq(req_b), .ImemAddr(addr_b), .ImemAck(ImemAck), .ImemData(ImemData),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .IfIdValid(valid_b), .IfIdInstr(instr_b), .IfIdPCPlus4(pcp4_b),
    .Opcode(op_b), .Rs(rs_b), .Rt(rt_b), .Rd(rd_b), .Shamt(sh_b), .Funct(fn_b),
    .Imm16(imm_b), .JumpAddr(ja_b)
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] data;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pcp4;
  } vec_t;

  localparam int NV = 24;
  vec_t tv [NV];

  function automatic vec_t mk(input logic r, input logic a, input logic [31:0] d,
                              input logic s, input logic b, input logic [31:0] t,
                              input logic q, input logic [31:0] ad, input logic v,
                              input logic [31:0] ins, input logic [31:0] p4);
    vec_t x;
    x.rst = r; x.ack = a; x.data = d; x.stall = s; x.br = b; x.tgt = t;
    x.req = q; x.addr = ad; x.valid = v; x.instr = ins; x.pcp4 = p4;
    return x;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    // Inputs apply to the edge ending the step; expected values are the
    // outputs visible during the step (all outputs are register-driven).
    //          rst ack data          stl br  tgt           req addr          vld instr         pcp4
    tv[0]  = mk(1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    tv[1]  = mk(0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    tv[2]  = mk(0, 1, 32'h2008_0003,  0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);
    tv[3]  = mk(0, 1, 32'h2008_FFFD,  1, 0, 32'h0,         1, 32'h4,         1, 32'h2008_0003, 32'h4);
    tv[4]  = mk(0, 0, 32'h0,          1, 0, 32'h0,         0, 32'h8,         1, 32'h2008_0003, 32'h4);
    tv[5]  = mk(0, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,         0, 32'h8,         1, 32'h2008_0003, 32'h4);
    tv[6]  = mk(0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h8,         1, 32'h2008_0003, 32'h4);
    tv[7]  = mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h8,         1, 32'h2008_FFFD, 32'h8);
    tv[8]  = mk(0, 0, 32'h0,          0, 1, 32'h100,       1, 32'h8,         0, 32'h2008_FFFD, 32'h8);
    tv[9]  = mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h8,         0, 32'h2008_FFFD, 32'h8);
    tv[10] = mk(0, 1, 32'h1111_1111,  0, 0, 32'h0,         1, 32'h8,         0, 32'h2008_FFFD, 32'h8);
    tv[11] = mk(0, 1, 32'h2222_2222,  1, 1, 32'h40,        1, 32'h100,       0, 32'h2008_FFFD, 32'h8);
    tv[12] = mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h40,        0, 32'h2008_FFFD, 32'h8);
    tv[13] = mk(0, 1, 32'h3C01_1234,  0, 0, 32'h0,         1, 32'h40,        0, 32'h2008_FFFD, 32'h8);
    tv[14] = mk(0, 0, 32'h0,          0, 1, 32'h200,       1, 32'h44,        1, 32'h3C01_1234, 32'h44);
    tv[15] = mk(0, 0, 32'h0,          0, 1, 32'h300,       1, 32'h44,        0, 32'h3C01_1234, 32'h44);
    tv[16] = mk(0, 1, 32'h5555_5555,  0, 0, 32'h0,         1, 32'h44,        0, 32'h3C01_1234, 32'h44);
    tv[17] = mk(0, 1, 32'hAAAA_5555,  1, 0, 32'h0,         1, 32'h300,       0, 32'h3C01_1234, 32'h44);
    tv[18] = mk(0, 0, 32'h0,          1, 1, 32'h500,       0, 32'h304,       0, 32'h3C01_1234, 32'h44);
    tv[19] = mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h500,       0, 32'h3C01_1234, 32'h44);
    tv[20] = mk(0, 0, 32'h0,          0, 1, 32'h600,       1, 32'h500,       0, 32'h3C01_1234, 32'h44);
    tv[21] = mk(1, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    tv[22] = mk(0, 1, 32'h0BAD_0BAD,  0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         32'h0);
    tv[23] = mk(0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0);

    rst2 = 1'b1;

    for (int i = 0; i < NV; i++) begin
      rst          = tv[i].rst;
      ImemAck      = tv[i].ack;
      ImemData     = tv[i].data;
      Stall        = tv[i].stall;
      BranchTaken  = tv[i].br;
      BranchTarget = tv[i].tgt;
      #1;
      chk("ImemReq",     i, {31'h0, req_a},   {31'h0, tv[i].req});
      chk("ImemAddr",    i, addr_a,           tv[i].addr);
      chk("IfIdValid",   i, {31'h0, valid_a}, {31'h0, tv[i].valid});
      chk("IfIdInstr",   i, instr_a,          tv[i].instr);
      chk("IfIdPCPlus4", i, pcp4_a,           tv[i].pcp4);
      chk("fields",      i, {op_a, rs_a, rt_a, rd_a, sh_a, fn_a}, tv[i].instr);
      chk("Imm16",       i, {16'h0, imm_a},   {16'h0, tv[i].instr[15:0]});
      chk("JumpAddr",    i, {6'h0, ja_a},     {6'h0, tv[i].instr[25:0]});
      @(posedge clk);
      #1;
    end

    // Explicit decoded-field spot checks after the first real fetch.
    // (Step 3 above showed word 2008_0003; re-verify its named fields.)

    // Wrapping RESET_PC: PC+4 of 32'hFFFF_FFFC is 0.
    rst = 1'b1;
    ImemAck = 1'b0; ImemData = 32'h0; Stall = 1'b0;
    BranchTaken = 1'b0; BranchTarget = 32'h0;
    #1;
    chk("wrap reset addr", 100, addr_b, 32'hFFFF_FFFC);
    chk("wrap reset req",  100, {31'h0, req_b}, 32'h0);
    rst2 = 1'b0;
    @(posedge clk); #1;
    chk("wrap req",  101, {31'h0, req_b}, 32'h1);
    chk("wrap addr", 101, addr_b, 32'hFFFF_FFFC);
    ImemAck = 1'b1; ImemData = 32'h0000_0020;
    @(posedge clk); #1;
    ImemAck = 1'b0; ImemData = 32'h0;
    #1;
    chk("wrap valid", 102, {31'h0, valid_b}, 32'h1);
    chk("wrap instr", 102, instr_b, 32'h0000_0020);
    chk("wrap pcp4",  102, pcp4_b, 32'h0);
    chk("wrap next addr", 102, addr_b, 32'h0);
    chk("wrap Funct", 102, {26'h0, fn_b}, 32'h20);

    // Named-field check on a known word via the main instance.
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ImemAck = 1'b1; ImemData = 32'h2008_0003;
    @(posedge clk); #1;
    ImemAck = 1'b0; ImemData = 32'h0;
    #1;
    chk("Rt",    103, {27'h0, rt_a},  32'h8);
    chk("Imm16 named", 103, {16'h0, imm_a}, 32'h3);
    chk("PCPlus4 named", 103, pcp4_a, 32'h4);
    chk("next addr named", 103, addr_a, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
